// File: rtl/id_stage_pkg.sv
// Shared bus widths, bus layouts, opcode constants and operand-forwarding helper for the ID stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package id_stage_pkg;

    localparam int FS_TO_DS_BUS_WD = 64;
    localparam int BR_BUS_WD       = 34;
    localparam int DS_TO_ES_BUS_WD = 136;
    localparam int ES_FWD_BUS_WD   = 39;
    localparam int MS_FWD_BUS_WD   = 38;
    localparam int WS_TO_RF_BUS_WD = 38;

    // alu_op bit positions
    localparam int ALU_OP_WD = 12;
    localparam int ALU_ADD   = 0;
    localparam int ALU_SUB   = 1;
    localparam int ALU_SLT   = 2;
    localparam int ALU_SLTU  = 3;
    localparam int ALU_AND   = 4;
    localparam int ALU_NOR   = 5;
    localparam int ALU_OR    = 6;
    localparam int ALU_XOR   = 7;
    localparam int ALU_SLL   = 8;
    localparam int ALU_SRL   = 9;
    localparam int ALU_SRA   = 10;
    localparam int ALU_LUI   = 11;

    // primary opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;

    // SPECIAL function codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fs_to_ds_t;

    typedef struct packed {
        logic [ALU_OP_WD-1:0] alu_op;
        logic                 load_op;
        logic                 src1_is_sa;
        logic                 src1_is_pc;
        logic                 src2_is_imm;
        logic                 src2_is_8;
        logic                 gr_we;
        logic                 mem_we;
        logic [4:0]           dest;
        logic [15:0]          imm;
        logic [31:0]          rs_value;
        logic [31:0]          rt_value;
        logic [31:0]          pc;
    } ds_to_es_t;

    typedef struct packed {
        logic        br_stall;
        logic        br_taken;
        logic [31:0] br_target;
    } br_t;

    typedef struct packed {
        logic        es_valid;
        logic        es_load;
        logic [4:0]  es_dest;
        logic [31:0] es_result;
    } es_fwd_t;

    typedef struct packed {
        logic        ms_valid;
        logic [4:0]  ms_dest;
        logic [31:0] ms_result;
    } ms_fwd_t;

    typedef struct packed {
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } ws_rf_t;

    // Youngest producer wins: EX, then MEM, then the value being written back this cycle, then the array.
    function automatic logic [31:0] fwd_operand(
        input logic [4:0]  addr,
        input es_fwd_t     es,
        input ms_fwd_t     ms,
        input ws_rf_t      ws,
        input logic [31:0] rf_val
    );
        logic [31:0] v;
        v = rf_val;
        if (addr == 5'd0)
            v = 32'd0;
        else if (es.es_valid && es.es_dest == addr)
            v = es.es_result;
        else if (ms.ms_valid && ms.ms_dest == addr)
            v = ms.ms_result;
        else if (ws.rf_we && ws.rf_waddr == addr)
            v = ws.rf_wdata;
        return v;
    endfunction

endpackage

// File: rtl/id_stage_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port; $0 reads as zero.
// Latency: reads combinational, write visible after the clock edge.
// Backpressure: none.
module id_stage_regfile (
    input  logic        i_clk,
    input  logic [4:0]  i_raddr1,
    output logic [31:0] o_rdata1,
    input  logic [4:0]  i_raddr2,
    output logic [31:0] o_rdata2,
    input  logic        i_we,
    input  logic [4:0]  i_waddr,
    input  logic [31:0] i_wdata
);

    logic [31:0] r_rf [32];

    // Write port; register 0 is never written so it stays hardwired to zero on read.
    always_ff @(posedge i_clk) begin
        if (i_we && i_waddr != 5'd0)
            r_rf[i_waddr] <= i_wdata;
    end

    assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_rf[i_raddr1];
    assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_rf[i_raddr2];

endmodule

// File: rtl/id_stage.sv
// MIPS decode stage: decode, operand forwarding, load-use stall, branch/jump resolution.
// Latency: one cycle from fetch handshake to the bundle being presented to EX.
// Backpressure: holds the instruction while EX refuses or a load-use hazard exists; ds_allowin drops.
module id_stage
    import id_stage_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_es_allowin,
    output logic                       o_ds_allowin,
    input  logic                       i_fs_to_ds_valid,
    input  logic [FS_TO_DS_BUS_WD-1:0] i_fs_to_ds_bus,
    output logic                       o_ds_to_es_valid,
    output logic [DS_TO_ES_BUS_WD-1:0] o_ds_to_es_bus,
    output logic [BR_BUS_WD-1:0]       o_br_bus,
    input  logic [ES_FWD_BUS_WD-1:0]   i_es_fwd_bus,
    input  logic [MS_FWD_BUS_WD-1:0]   i_ms_fwd_bus,
    input  logic [WS_TO_RF_BUS_WD-1:0] i_ws_to_rf_bus
);

    logic      r_ds_valid;
    fs_to_ds_t r_fs_bus;

    es_fwd_t   w_es;
    ms_fwd_t   w_ms;
    ws_rf_t    w_ws;
    assign w_es = i_es_fwd_bus;
    assign w_ms = i_ms_fwd_bus;
    assign w_ws = i_ws_to_rf_bus;

    // instruction fields
    logic [5:0]  w_op, w_func;
    logic [4:0]  w_rs, w_rt, w_rd;
    logic [15:0] w_imm;
    logic [25:0] w_index;
    assign w_op    = r_fs_bus.inst[31:26];
    assign w_rs    = r_fs_bus.inst[25:21];
    assign w_rt    = r_fs_bus.inst[20:16];
    assign w_rd    = r_fs_bus.inst[15:11];
    assign w_func  = r_fs_bus.inst[5:0];
    assign w_imm   = r_fs_bus.inst[15:0];
    assign w_index = r_fs_bus.inst[25:0];

    // instruction class decode
    logic w_special;
    logic w_addu, w_subu, w_slt, w_sltu, w_and, w_or, w_xor, w_nor;
    logic w_sll, w_srl, w_sra, w_jr;
    logic w_addiu, w_lui, w_lw, w_sw, w_beq, w_bne, w_jal;
    logic w_shift, w_r_alu, w_is_br;
    assign w_special = (w_op == OP_SPECIAL);
    assign w_addu  = w_special && w_func == FN_ADDU;
    assign w_subu  = w_special && w_func == FN_SUBU;
    assign w_slt   = w_special && w_func == FN_SLT;
    assign w_sltu  = w_special && w_func == FN_SLTU;
    assign w_and   = w_special && w_func == FN_AND;
    assign w_or    = w_special && w_func == FN_OR;
    assign w_xor   = w_special && w_func == FN_XOR;
    assign w_nor   = w_special && w_func == FN_NOR;
    assign w_sll   = w_special && w_func == FN_SLL;
    assign w_srl   = w_special && w_func == FN_SRL;
    assign w_sra   = w_special && w_func == FN_SRA;
    assign w_jr    = w_special && w_func == FN_JR;
    assign w_addiu = (w_op == OP_ADDIU);
    assign w_lui   = (w_op == OP_LUI);
    assign w_lw    = (w_op == OP_LW);
    assign w_sw    = (w_op == OP_SW);
    assign w_beq   = (w_op == OP_BEQ);
    assign w_bne   = (w_op == OP_BNE);
    assign w_jal   = (w_op == OP_JAL);
    assign w_shift = w_sll | w_srl | w_sra;
    assign w_r_alu = w_addu | w_subu | w_slt | w_sltu | w_and | w_or | w_xor | w_nor | w_shift;
    assign w_is_br = w_beq | w_bne | w_jal | w_jr;

    logic [ALU_OP_WD-1:0] w_alu_op;
    assign w_alu_op[ALU_ADD]  = w_addu | w_addiu | w_lw | w_sw | w_jal;
    assign w_alu_op[ALU_SUB]  = w_subu;
    assign w_alu_op[ALU_SLT]  = w_slt;
    assign w_alu_op[ALU_SLTU] = w_sltu;
    assign w_alu_op[ALU_AND]  = w_and;
    assign w_alu_op[ALU_NOR]  = w_nor;
    assign w_alu_op[ALU_OR]   = w_or;
    assign w_alu_op[ALU_XOR]  = w_xor;
    assign w_alu_op[ALU_SLL]  = w_sll;
    assign w_alu_op[ALU_SRL]  = w_srl;
    assign w_alu_op[ALU_SRA]  = w_sra;
    assign w_alu_op[ALU_LUI]  = w_lui;

    logic       w_gr_we;
    logic [4:0] w_dest;
    assign w_gr_we = w_r_alu | w_addiu | w_lui | w_lw | w_jal;

    // Destination selection; forced to zero for anything that does not write a register.
    always_comb begin
        w_dest = 5'd0;
        if (w_r_alu)
            w_dest = w_rd;
        else if (w_addiu || w_lui || w_lw)
            w_dest = w_rt;
        else if (w_jal)
            w_dest = 5'd31;
    end

    // register file and forwarding
    logic [31:0] w_rf_rdata1, w_rf_rdata2, w_rs_value, w_rt_value;

    id_stage_regfile u_regfile (
        .i_clk    (i_clk),
        .i_raddr1 (w_rs),
        .o_rdata1 (w_rf_rdata1),
        .i_raddr2 (w_rt),
        .o_rdata2 (w_rf_rdata2),
        .i_we     (w_ws.rf_we),
        .i_waddr  (w_ws.rf_waddr),
        .i_wdata  (w_ws.rf_wdata)
    );

    assign w_rs_value = fwd_operand(w_rs, w_es, w_ms, w_ws, w_rf_rdata1);
    assign w_rt_value = fwd_operand(w_rt, w_es, w_ms, w_ws, w_rf_rdata2);

    // load-use hazard: only sources the instruction actually reads can stall it
    logic w_rs_used, w_rt_used, w_rs_hazard, w_rt_hazard, w_ds_ready_go;
    assign w_rs_used   = (w_r_alu & ~w_shift) | w_addiu | w_lw | w_sw | w_beq | w_bne | w_jr;
    assign w_rt_used   = w_r_alu | w_sw | w_beq | w_bne;
    assign w_rs_hazard = w_rs_used && w_rs != 5'd0 && w_es.es_valid && w_es.es_load && w_es.es_dest == w_rs;
    assign w_rt_hazard = w_rt_used && w_rt != 5'd0 && w_es.es_valid && w_es.es_load && w_es.es_dest == w_rt;
    assign w_ds_ready_go = ~(w_rs_hazard | w_rt_hazard);

    // branch resolution
    logic [31:0] w_pc_plus4, w_br_offset, w_target;
    logic        w_take, w_br_taken, w_br_stall;
    br_t         w_br;
    assign w_pc_plus4  = r_fs_bus.pc + 32'd4;
    assign w_br_offset = {{14{w_imm[15]}}, w_imm, 2'b00};

    // Target select among conditional branch, jal and jr.
    always_comb begin
        w_target = w_pc_plus4 + w_br_offset;
        if (w_jal)
            w_target = {w_pc_plus4[31:28], w_index, 2'b00};
        else if (w_jr)
            w_target = w_rs_value;
    end

    assign w_take     = (w_beq & (w_rs_value == w_rt_value)) | (w_bne & (w_rs_value != w_rt_value)) | w_jal | w_jr;
    assign w_br_taken = r_ds_valid & w_ds_ready_go & w_take;
    assign w_br_stall = r_ds_valid & w_is_br & ~w_ds_ready_go;
    // target gated so an idle stage presents an all-zero branch bus
    assign w_br.br_stall  = w_br_stall;
    assign w_br.br_taken  = w_br_taken;
    assign w_br.br_target = w_br_taken ? w_target : 32'd0;
    assign o_br_bus       = w_br;

    // handshake
    logic w_ds_allowin;
    assign w_ds_allowin     = ~r_ds_valid | (w_ds_ready_go & i_es_allowin);
    assign o_ds_allowin     = w_ds_allowin;
    assign o_ds_to_es_valid = r_ds_valid & w_ds_ready_go;

    // Stage valid: reset drops any held instruction; otherwise refill whenever the stage can accept.
    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_ds_valid <= 1'b0;
        else if (w_ds_allowin)
            r_ds_valid <= i_fs_to_ds_valid;
    end

    // Instruction/PC capture on an accepted fetch transfer.
    always_ff @(posedge i_clk) begin
        if (i_fs_to_ds_valid && w_ds_allowin)
            r_fs_bus <= i_fs_to_ds_bus;
    end

    // decoded bundle to EX
    ds_to_es_t w_ds_to_es;
    assign w_ds_to_es.alu_op      = w_alu_op;
    assign w_ds_to_es.load_op     = w_lw;
    assign w_ds_to_es.src1_is_sa  = w_shift;
    assign w_ds_to_es.src1_is_pc  = w_jal;
    assign w_ds_to_es.src2_is_imm = w_addiu | w_lui | w_lw | w_sw;
    assign w_ds_to_es.src2_is_8   = w_jal;
    assign w_ds_to_es.gr_we       = w_gr_we;
    assign w_ds_to_es.mem_we      = w_sw;
    assign w_ds_to_es.dest        = w_dest;
    assign w_ds_to_es.imm         = w_imm;
    assign w_ds_to_es.rs_value    = w_rs_value;
    assign w_ds_to_es.rt_value    = w_rt_value;
    assign w_ds_to_es.pc          = r_fs_bus.pc;
    assign o_ds_to_es_bus         = w_ds_to_es;

endmodule

// File: tb/tb_id_stage.sv
// Directed-vector bench for id_stage: forwarding priority, load-use stall, branches, jumps, hold and reset.
// Latency: checks one cycle after each instruction is accepted.
// Backpressure: exercises es_allowin low with a taken branch held in ID.
module tb_id_stage;

    logic         clk;
    logic         reset;
    logic         es_allowin;
    logic         ds_allowin;
    logic         fs_to_ds_valid;
    logic [63:0]  fs_to_ds_bus;
    logic         ds_to_es_valid;
    logic [135:0] ds_to_es_bus;
    logic [33:0]  br_bus;
    logic [38:0]  es_fwd_bus;
    logic [37:0]  ms_fwd_bus;
    logic [37:0]  ws_to_rf_bus;

    int vectors = 0;
    int miscompares = 0;

    id_stage dut (
        .i_clk            (clk),
        .i_reset          (reset),
        .i_es_allowin     (es_allowin),
        .o_ds_allowin     (ds_allowin),
        .i_fs_to_ds_valid (fs_to_ds_valid),
        .i_fs_to_ds_bus   (fs_to_ds_bus),
        .o_ds_to_es_valid (ds_to_es_valid),
        .o_ds_to_es_bus   (ds_to_es_bus),
        .o_br_bus         (br_bus),
        .i_es_fwd_bus     (es_fwd_bus),
        .i_ms_fwd_bus     (ms_fwd_bus),
        .i_ws_to_rf_bus   (ws_to_rf_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // bundle fields, sliced by bit position of the documented layout
    wire [11:0] d_alu_op      = ds_to_es_bus[135:124];
    wire        d_src1_is_sa  = ds_to_es_bus[122];
    wire        d_src1_is_pc  = ds_to_es_bus[121];
    wire        d_src2_is_8   = ds_to_es_bus[119];
    wire        d_gr_we       = ds_to_es_bus[118];
    wire [4:0]  d_dest        = ds_to_es_bus[116:112];
    wire [15:0] d_imm         = ds_to_es_bus[111:96];
    wire [31:0] d_rs_value    = ds_to_es_bus[95:64];
    wire [31:0] d_rt_value    = ds_to_es_bus[63:32];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clear_fwd();
        es_fwd_bus   = '0;
        ms_fwd_bus   = '0;
        ws_to_rf_bus = '0;
    endtask

    task automatic load_inst(input logic [31:0] inst, input logic [31:0] pc);
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {inst, pc};
        tick();
        fs_to_ds_valid = 1'b0;
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        ws_to_rf_bus = {1'b1, a, d};
        tick();
        ws_to_rf_bus = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1; es_allowin = 1'b1; fs_to_ds_valid = 1'b0; fs_to_ds_bus = '0;
        clear_fwd();
        tick(); tick();
        reset = 1'b0;
        settle();
        vectors++; if (ds_allowin !== 1'b1) begin miscompares++; $display("FAIL reset_allowin got=%b exp=1", ds_allowin); end
        vectors++; if (ds_to_es_valid !== 1'b0) begin miscompares++; $display("FAIL reset_es_valid got=%b exp=0", ds_to_es_valid); end
        vectors++; if (br_bus !== 34'h0) begin miscompares++; $display("FAIL reset_br_bus got=%h exp=0", br_bus); end
    endtask

    task automatic test_ex_forward();
        clear_fwd();
        load_inst({6'h09, 5'd0, 5'd1, 16'd5}, 32'hBFC00000);        // addiu $1,$0,5
        settle();
        vectors++; if (ds_to_es_valid !== 1'b1) begin miscompares++; $display("FAIL addiu_valid got=%b exp=1", ds_to_es_valid); end
        vectors++; if (d_dest !== 5'd1) begin miscompares++; $display("FAIL addiu_dest got=%0d exp=1", d_dest); end
        vectors++; if (d_alu_op !== 12'h001) begin miscompares++; $display("FAIL addiu_alu_op got=%h exp=001", d_alu_op); end
        vectors++; if (d_imm !== 16'd5) begin miscompares++; $display("FAIL addiu_imm got=%h exp=0005", d_imm); end
        load_inst({6'd0, 5'd1, 5'd1, 5'd2, 5'd0, 6'h21}, 32'hBFC00004); // addu $2,$1,$1
        es_fwd_bus   = {1'b1, 1'b0, 5'd1, 32'd5};
        ms_fwd_bus   = {1'b1, 5'd1, 32'd77};
        ws_to_rf_bus = {1'b1, 5'd1, 32'd88};
        settle();
        vectors++; if (ds_to_es_valid !== 1'b1) begin miscompares++; $display("FAIL addu_no_stall got=%b exp=1", ds_to_es_valid); end
        vectors++; if (d_rs_value !== 32'd5) begin miscompares++; $display("FAIL addu_rs_ex got=%h exp=5", d_rs_value); end
        vectors++; if (d_rt_value !== 32'd5) begin miscompares++; $display("FAIL addu_rt_ex got=%h exp=5", d_rt_value); end
        vectors++; if (d_dest !== 5'd2) begin miscompares++; $display("FAIL addu_dest got=%0d exp=2", d_dest); end
        es_fwd_bus = '0;
        settle();
        vectors++; if (d_rs_value !== 32'd77) begin miscompares++; $display("FAIL addu_rs_mem got=%h exp=4d", d_rs_value); end
        ms_fwd_bus = '0;
        settle();
        vectors++; if (d_rs_value !== 32'd88) begin miscompares++; $display("FAIL addu_rs_wb got=%h exp=58", d_rs_value); end
    endtask

    task automatic test_load_use();
        clear_fwd();
        load_inst({6'd0, 5'd3, 5'd0, 5'd4, 5'd0, 6'h21}, 32'hBFC00008); // addu $4,$3,$0
        es_fwd_bus   = {1'b1, 1'b1, 5'd3, 32'h12345678};
        ws_to_rf_bus = {1'b1, 5'd0, 32'hFFFFFFFF};
        settle();
        vectors++; if (ds_to_es_valid !== 1'b0) begin miscompares++; $display("FAIL lu_stall_valid got=%b exp=0", ds_to_es_valid); end
        vectors++; if (ds_allowin !== 1'b0) begin miscompares++; $display("FAIL lu_stall_allowin got=%b exp=0", ds_allowin); end
        tick();
        es_fwd_bus = '0;
        ms_fwd_bus = {1'b1, 5'd3, 32'hDEADBEEF};
        settle();
        vectors++; if (ds_to_es_valid !== 1'b1) begin miscompares++; $display("FAIL lu_release got=%b exp=1", ds_to_es_valid); end
        vectors++; if (d_rs_value !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lu_rs_mem got=%h exp=deadbeef", d_rs_value); end
        vectors++; if (d_rt_value !== 32'd0) begin miscompares++; $display("FAIL lu_rt_zero got=%h exp=0", d_rt_value); end
        clear_fwd();
        // sll with a stray rs field equal to the load destination must not stall
        load_inst({6'd0, 5'd3, 5'd7, 5'd9, 5'd2, 6'h00}, 32'hBFC0000C);
        es_fwd_bus = {1'b1, 1'b1, 5'd3, 32'h0};
        settle();
        vectors++; if (ds_to_es_valid !== 1'b1) begin miscompares++; $display("FAIL sll_unused_rs got=%b exp=1", ds_to_es_valid); end
        vectors++; if (d_src1_is_sa !== 1'b1) begin miscompares++; $display("FAIL sll_src1_is_sa got=%b exp=1", d_src1_is_sa); end
    endtask

    task automatic test_branch();
        clear_fwd();
        load_inst({6'h04, 5'd5, 5'd6, 16'h0004}, 32'hBFC00010);         // beq $5,$6 equal
        settle();
        vectors++; if (br_bus !== {2'b01, 32'hBFC00024}) begin miscompares++; $display("FAIL beq_eq got=%h exp=%h", br_bus, {2'b01, 32'hBFC00024}); end
        vectors++; if (d_gr_we !== 1'b0 || d_dest !== 5'd0) begin miscompares++; $display("FAIL beq_no_write got=%b/%0d exp=0/0", d_gr_we, d_dest); end
        load_inst({6'h04, 5'd5, 5'd7, 16'h0004}, 32'hBFC00010);         // beq $5,$7 unequal
        settle();
        vectors++; if (br_bus[33:32] !== 2'b00) begin miscompares++; $display("FAIL beq_ne stall/taken got=%b exp=00", br_bus[33:32]); end
        load_inst({6'h05, 5'd5, 5'd7, 16'hFFFF}, 32'hBFC00020);         // bne $5,$7 backward
        settle();
        vectors++; if (br_bus !== {2'b01, 32'hBFC00020}) begin miscompares++; $display("FAIL bne_taken got=%h exp=%h", br_bus, {2'b01, 32'hBFC00020}); end
    endtask

    task automatic test_branch_load_stall();
        clear_fwd();
        load_inst({6'h04, 5'd5, 5'd6, 16'h0004}, 32'hBFC00010);
        es_fwd_bus = {1'b1, 1'b1, 5'd5, 32'h0};
        settle();
        vectors++; if (br_bus[33:32] !== 2'b10) begin miscompares++; $display("FAIL brs_stall got=%b exp=10", br_bus[33:32]); end
        vectors++; if (ds_to_es_valid !== 1'b0) begin miscompares++; $display("FAIL brs_valid got=%b exp=0", ds_to_es_valid); end
        tick();
        es_fwd_bus = '0;
        ms_fwd_bus = {1'b1, 5'd5, 32'h00001234};
        settle();
        vectors++; if (br_bus !== {2'b01, 32'hBFC00024}) begin miscompares++; $display("FAIL brs_resolved got=%h exp=%h", br_bus, {2'b01, 32'hBFC00024}); end
        ms_fwd_bus = {1'b1, 5'd5, 32'h00004321};
        settle();
        vectors++; if (br_bus[32] !== 1'b0) begin miscompares++; $display("FAIL brs_fwd_ne got=%b exp=0", br_bus[32]); end
    endtask

    task automatic test_jal_jr();
        clear_fwd();
        load_inst({6'h03, 26'h0000040}, 32'hBFC00100);                  // jal
        settle();
        vectors++; if (br_bus !== {2'b01, 32'hB0000100}) begin miscompares++; $display("FAIL jal_target got=%h exp=%h", br_bus, {2'b01, 32'hB0000100}); end
        vectors++; if (d_dest !== 5'd31 || d_gr_we !== 1'b1) begin miscompares++; $display("FAIL jal_dest got=%0d/%b exp=31/1", d_dest, d_gr_we); end
        vectors++; if (d_src2_is_8 !== 1'b1 || d_src1_is_pc !== 1'b1) begin miscompares++; $display("FAIL jal_srcs got=%b%b exp=11", d_src2_is_8, d_src1_is_pc); end
        load_inst({6'd0, 5'd31, 15'd0, 6'h08}, 32'hBFC00104);           // jr $31
        es_fwd_bus = {1'b1, 1'b0, 5'd31, 32'hBFC00108};
        settle();
        vectors++; if (br_bus !== {2'b01, 32'hBFC00108}) begin miscompares++; $display("FAIL jr_target got=%h exp=%h", br_bus, {2'b01, 32'hBFC00108}); end
        vectors++; if (d_gr_we !== 1'b0) begin miscompares++; $display("FAIL jr_gr_we got=%b exp=0", d_gr_we); end
    endtask

    task automatic test_hold_reset();
        clear_fwd();
        load_inst({6'h04, 5'd5, 5'd6, 16'h0004}, 32'hBFC00010);
        es_allowin     = 1'b0;
        fs_to_ds_valid = 1'b1;
        fs_to_ds_bus   = {32'h24090001, 32'hBFC00014};
        for (int i = 0; i < 3; i++) begin
            settle();
            vectors++; if (ds_allowin !== 1'b0) begin miscompares++; $display("FAIL hold_allowin cyc=%0d got=%b exp=0", i, ds_allowin); end
            vectors++; if (br_bus !== {2'b01, 32'hBFC00024}) begin miscompares++; $display("FAIL hold_taken cyc=%0d got=%h exp=%h", i, br_bus, {2'b01, 32'hBFC00024}); end
            tick();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        settle();
        vectors++; if (ds_to_es_valid !== 1'b0) begin miscompares++; $display("FAIL rst_hold_valid got=%b exp=0", ds_to_es_valid); end
        vectors++; if (br_bus !== 34'h0) begin miscompares++; $display("FAIL rst_hold_br got=%h exp=0", br_bus); end
        vectors++; if (ds_allowin !== 1'b1) begin miscompares++; $display("FAIL rst_hold_allowin got=%b exp=1", ds_allowin); end
        fs_to_ds_valid = 1'b0;
        es_allowin     = 1'b1;
    endtask

    initial begin
        test_reset();
        write_reg(5'd5, 32'h00001234);
        write_reg(5'd6, 32'h00001234);
        write_reg(5'd7, 32'h00000099);
        test_ex_forward();
        test_load_use();
        test_branch();
        test_branch_load_stall();
        test_jal_jr();
        test_hold_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired vectors=%0d", vectors);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the five-stage in-order MIPS pipeline. It sits directly downstream of the fetch stage and consumes its `{inst, pc}` bus. It reads the register file, resolves operand hazards by forwarding and stalling, and resolves branches and jumps in ID. It returns `br_bus` (stall/taken/target) to fetch and emits a decoded bundle to the execute stage.

## Interface
- Parameters: none. Bus widths are shared constants:
  - `FS_TO_DS_BUS_WD` = 64
  - `BR_BUS_WD` = 34
  - `DS_TO_ES_BUS_WD` = 136
  - `ES_FWD_BUS_WD` = 39
  - `MS_FWD_BUS_WD` = 38
  - `WS_TO_RF_BUS_WD` = 38
- Ports:
  - `clk  in  1`: single clock, rising edge.
  - `reset  in  1`: synchronous, active-high.
  - `es_allowin  in  1`: execute stage can accept.
  - `ds_allowin  out  1`: ID can accept from fetch.
  - `fs_to_ds_valid  in  1`: fetch bus valid.
  - `fs_to_ds_bus  in  64`: `{inst[31:0], pc[31:0]}`.
  - `ds_to_es_valid  out  1`: decoded bundle valid.
  - `ds_to_es_bus  out  136`: `{alu_op[11:0], load_op, src1_is_sa, src1_is_pc, src2_is_imm, src2_is_8, gr_we, mem_we, dest[4:0], imm[15:0], rs_value[31:0], rt_value[31:0], pc[31:0]}`.
  - `br_bus  out  34`: `{br_stall, br_taken, br_target[31:0]}`.
  - `es_fwd_bus  in  39`: `{es_valid, es_load, es_dest[4:0], es_result[31:0]}`.
  - `ms_fwd_bus  in  38`: `{ms_valid, ms_dest[4:0], ms_result[31:0]}`; for loads, `ms_result` is the load data.
  - `ws_to_rf_bus  in  38`: `{rf_we, rf_waddr[4:0], rf_wdata[31:0]}`.

## Operation
- Supported instructions: addu, subu, slt, sltu, and, or, xor, nor, sll, srl, sra, addiu, lui, lw, sw, beq, bne, jal, jr.
  - Any other opcode decodes as a NOP: `gr_we` = 0, `mem_we` = 0, no branch.
- Destination:
  - R-type writes `rd`; addiu/lui/lw write `rt`; jal writes 31.
  - `dest` = 0 whenever `gr_we` = 0.
  - jal uses `src1_is_pc` + `src2_is_8` (link = pc+8).
- Operand read order, highest priority first:
  1. EX, when `es_valid` and `es_dest` = reg and reg ≠ 0.
  2. MEM, same condition.
  3. WB, when `rf_we` and `rf_waddr` = reg and reg ≠ 0.
  4. Register file.
  - Register 0 always reads 0.
- Source usage:
  - `rs` is used by R-type ALU ops (except shifts), addiu, lw, sw, beq, bne, jr.
  - `rt` is used by R-type, sw, beq, bne.
  - Only a used source can cause a stall.
- Load-use stall: `ds_ready_go` = 0 while a used source matches `es_dest` with `es_load` = 1. Otherwise `ds_ready_go` = 1.
- Branch resolution (only when `ds_valid` and `ds_ready_go`):
  - beq taken when rs == rt; bne taken when rs != rt. Target = pc + 4 + (sext(imm) << 2).
  - jal target = `{pc_plus4[31:28], index, 2'b00}`.
  - jr target = rs value.
  - jal and jr are always taken.
- `br_stall` = `ds_valid` & is_branch_or_jump & !`ds_ready_go`.
- `br_taken` is 0 whenever `br_stall` = 1. `br_target` is don't-care when not taken.
- Handshake:
  - `ds_allowin` = !`ds_valid` | (`ds_ready_go` & `es_allowin`).
  - `ds_to_es_valid` = `ds_valid` & `ds_ready_go`.
  - On `ds_allowin`: `ds_valid` <= `fs_to_ds_valid`.
  - The bus register loads only on `fs_to_ds_valid` & `ds_allowin`.
- Delay slot: the instruction in fetch while a branch sits in ID is the delay slot. It is never squashed.

## Timing
- Reset values:
  - `ds_valid` = 0, so `ds_to_es_valid` = 0 and `br_bus` = 0.
  - `ds_allowin` = 1.
  - Register-file contents are not reset.
- Latency: one cycle. An instruction accepted at edge N is presented to EX during cycle N+1 if no stall.
- `br_taken` and `br_target` are combinational from the ID register. They stay asserted every cycle the branch remains in ID, including while `es_allowin` = 0.
- Register-file write happens at the clock edge. The same-cycle read uses the WB forward path, never stale data.
- Stall release: when the load leaves EX it matches in MEM, so `ds_ready_go` rises with no extra bubble.
- Reset asserted mid-stall: all valids clear at that edge; the held instruction is dropped.

## Structure
- Shared header `mycpu.h` holds all `*_BUS_WD` constants and the `alu_op` bit positions.
- One sub-module, `regfile`:
  - 32×32, two asynchronous read ports, one synchronous write port.
  - Writes to register 0 are ignored.
- Decode, forwarding, stall logic and branch logic stay in `id_stage`.

## Test plan
- addiu $1,$0,5 followed by addu $2,$1,$1 → $2 operand taken from EX forward. `ds_to_es_bus` `rs_value` = `rt_value` = 5, no stall cycle.
- lw $3 (EX, `es_load`=1) followed by addu $4,$3,$0 → `ds_ready_go` = 0 for exactly 1 cycle, then `rs_value` = MEM load data (0xDEADBEEF).
- beq $5,$6 at pc 0xBFC00010, imm 0x0004, with $5 = $6 → `br_taken` = 1, `br_target` = 0xBFC00024. Same with $5 ≠ $6 → `br_taken` = 0.
- beq whose rs is a load in EX → `br_stall` = 1, `br_taken` = 0 for 1 cycle, then resolved with forwarded value.
- jal at pc 0xBFC00100, index 0x0000040 → target 0xB0000100; `dest` = 31, `src2_is_8` = 1. jr $31 → target = forwarded $31.
- `es_allowin` = 0 for 3 cycles with a taken branch in ID → `ds_allowin` = 0 and `br_taken` held 3 cycles. Reset pulse during the hold → next cycle `ds_to_es_valid` = 0 and `br_bus` = 0.
